fft_frame_sequencer: RTL and testbench

Frame controller between the PDM-to-PCM front end and the `furry` spectrum core. It gates the PCM sample stream into fixed-length frames, starts one FFT per frame and waits for its result with a timeout. It then registers the amplitude and a running peak for the `SevenSegmentLED` driver, and enforces a display hold-off before the next frame.

---
 rtl/fft_frame_sequencer_pkg.sv | 25 ++
 rtl/fft_frame_sequencer_amp.sv | 53 +++++
 rtl/fft_frame_sequencer.sv | 116 +++++++++++
 tb/tb_fft_frame_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_frame_sequencer_pkg.sv
// Shared types and constants for the FFT frame sequencer and its display register.
package fft_frame_sequencer_pkg;

  localparam int SAMPLE_W = 16;
  localparam int AMP_W    = 9;
  localparam int DISP_W   = 32;

  localparam logic [7:0] MASK_LOW4  = 8'b1111_0000;
  localparam logic [7:0] MASK_ALL   = 8'h00;
  localparam logic [7:0] MASK_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    COLLECT     = 2'd1,
    WAIT_RESULT = 2'd2,
    HOLD        = 2'd3
  } seq_state_e;

  // Peak goes in the upper half-word, amplitude in the lower, both zero-extended.
  function automatic logic [DISP_W-1:0] format_display(input logic [AMP_W-1:0] amp,
                                                       input logic [AMP_W-1:0] peak);
    return {{(DISP_W/2-AMP_W){1'b0}}, peak, {(DISP_W/2-AMP_W){1'b0}}, amp};
  endfunction

endpackage

// File: rtl/fft_frame_sequencer_amp.sv
// Amplitude/peak register: max-tracking peak with clear, formatted for the LED driver.
module amp_peak_reg
  import fft_frame_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              result_valid,
  input  logic [AMP_W-1:0]  result_amp,
  input  logic              clear_peak,
  output logic [DISP_W-1:0] display_number,
  output logic [7:0]        display_mask,
  output logic              display_update
);

  logic [AMP_W-1:0] amp_q;
  logic [AMP_W-1:0] peak_q;
  logic [AMP_W-1:0] amp_d;
  logic [AMP_W-1:0] peak_d;
  logic             refresh;

  assign refresh = result_valid | clear_peak;

  // A clear that coincides with a fresh result keeps the result as the new peak.
  always_comb begin
    amp_d  = amp_q;
    peak_d = peak_q;
    if (result_valid) begin
      amp_d  = result_amp;
      peak_d = (clear_peak || (result_amp > peak_q)) ? result_amp : peak_q;
    end else if (clear_peak) begin
      peak_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      amp_q          <= '0;
      peak_q         <= '0;
      display_number <= '0;
      display_mask   <= MASK_BLANK;
      display_update <= 1'b0;
    end else begin
      amp_q          <= amp_d;
      peak_q         <= peak_d;
      display_update <= refresh;
      if (refresh) begin
        display_number <= format_display(amp_d, peak_d);
        display_mask   <= (peak_d == '0) ? MASK_LOW4 : MASK_ALL;
      end
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller: gates PCM samples into FFT frames, waits for the result with a
// timeout, drives the display register and enforces a hold-off between frames.
module fft_frame_sequencer
  import fft_frame_sequencer_pkg::*;
#(
  parameter int FRAME_LEN      = 64,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int HOLD_CYCLES    = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear_peak,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                fft_valid,
  input  logic [AMP_W-1:0]    fft_amplitude,
  output logic                fft_start,
  output logic [SAMPLE_W-1:0] fft_data,
  output logic                fft_data_valid,
  output logic [DISP_W-1:0]   display_number,
  output logic [7:0]          display_mask,
  output logic                display_update,
  output logic                busy,
  output logic                timeout_flag,
  output logic [7:0]          drop_count
);

  localparam int CNT_W  = (FRAME_LEN > 1)      ? $clog2(FRAME_LEN)      : 1;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1)    ? $clog2(HOLD_CYCLES)    : 1;

  localparam logic [CNT_W-1:0]  LAST_SAMPLE = CNT_W'(FRAME_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);

  seq_state_e        state_q;
  seq_state_e        state_d;
  logic [CNT_W-1:0]  sample_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  logic accept;
  logic drop;
  logic result_valid;
  logic timeout_hit;
  logic hold_done;

  assign accept       = (state_q == COLLECT) && sample_valid;
  assign drop         = sample_valid && ((state_q == WAIT_RESULT) || (state_q == HOLD));
  assign result_valid = (state_q == WAIT_RESULT) && fft_valid;
  assign timeout_hit  = (state_q == WAIT_RESULT) && !fft_valid && (tmo_cnt == TMO_LAST);
  assign hold_done    = (state_q == HOLD) && (hold_cnt == HOLD_LAST);

  // NOTE: state_d is defaulted before the case so every path assigns it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (enable) state_d = COLLECT;
      COLLECT:     if (accept && (sample_cnt == LAST_SAMPLE)) state_d = WAIT_RESULT;
      WAIT_RESULT: begin
        if (fft_valid)        state_d = HOLD;
        else if (timeout_hit) state_d = COLLECT;
      end
      HOLD:        if (hold_done) state_d = enable ? COLLECT : IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register here samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      busy           <= 1'b0;
      sample_cnt     <= '0;
      tmo_cnt        <= '0;
      hold_cnt       <= '0;
      fft_start      <= 1'b0;
      fft_data       <= '0;
      fft_data_valid <= 1'b0;
      timeout_flag   <= 1'b0;
      drop_count     <= '0;
    end else begin
      state_q        <= state_d;
      busy           <= (state_d != IDLE);
      fft_start      <= accept && (sample_cnt == '0);
      fft_data_valid <= accept;
      if (accept) fft_data <= sample_in;

      // Counters idle at zero outside their own state, so every entry starts fresh.
      if (state_q != COLLECT)  sample_cnt <= '0;
      else if (accept)         sample_cnt <= (sample_cnt == LAST_SAMPLE) ? '0 : sample_cnt + 1'b1;

      if (state_q != WAIT_RESULT) tmo_cnt <= '0;
      else                        tmo_cnt <= tmo_cnt + 1'b1;

      if (state_q != HOLD) hold_cnt <= '0;
      else                 hold_cnt <= hold_cnt + 1'b1;

      if (timeout_hit) timeout_flag <= 1'b1;
      if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 1'b1;
    end
  end

  amp_peak_reg u_amp_peak_reg (
    .clk            (clk),
    .reset          (reset),
    .result_valid   (result_valid),
    .result_amp     (fft_amplitude),
    .clear_peak     (clear_peak),
    .display_number (display_number),
    .display_mask   (display_mask),
    .display_update (display_update)
  );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer: random frames checked against a
// queue-based stream scoreboard and an arithmetic amp/peak/drop model.
module tb_fft_frame_sequencer;

  localparam int FRAME_LEN      = 4;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int HOLD_CYCLES    = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear_peak;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        fft_valid;
  logic [8:0]  fft_amplitude;
  logic        fft_start;
  logic [15:0] fft_data;
  logic        fft_data_valid;
  logic [31:0] display_number;
  logic [7:0]  display_mask;
  logic        display_update;
  logic        busy;
  logic        timeout_flag;
  logic [7:0]  drop_count;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        start;
    logic [15:0] data;
  } fwd_t;

  fwd_t exp_q[$];
  fwd_t obs_q[$];
  int   stray_starts  = 0;
  int   update_pulses = 0;
  int   exp_amp       = 0;
  int   exp_peak      = 0;
  int   drops_raw     = 0;

  always #5 clk = ~clk;

  fft_frame_sequencer #(
    .FRAME_LEN      (FRAME_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .clear_peak     (clear_peak),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .fft_valid      (fft_valid),
    .fft_amplitude  (fft_amplitude),
    .fft_start      (fft_start),
    .fft_data       (fft_data),
    .fft_data_valid (fft_data_valid),
    .display_number (display_number),
    .display_mask   (display_mask),
    .display_update (display_update),
    .busy           (busy),
    .timeout_flag   (timeout_flag),
    .drop_count     (drop_count)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (fft_data_valid) obs_q.push_back({fft_start, fft_data});
      else if (fft_start) stray_starts++;
      if (display_update) update_pulses++;
    end
  end

  function automatic logic [31:0] model_number();
    return {16'(exp_peak), 16'(exp_amp)};
  endfunction

  function automatic logic [7:0] model_mask();
    return (exp_peak == 0) ? 8'hF0 : 8'h00;
  endfunction

  function automatic logic [7:0] model_drops();
    return (drops_raw > 255) ? 8'd255 : 8'(drops_raw);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reset_outputs(input string tag);
    checks += 9;
    if (fft_start !== 1'b0)        begin failures++; $display("FAIL %s fft_start: got %b want 0", tag, fft_start); end
    if (fft_data !== 16'h0)        begin failures++; $display("FAIL %s fft_data: got %h want 0000", tag, fft_data); end
    if (fft_data_valid !== 1'b0)   begin failures++; $display("FAIL %s fft_data_valid: got %b want 0", tag, fft_data_valid); end
    if (display_number !== 32'h0)  begin failures++; $display("FAIL %s display_number: got %h want 00000000", tag, display_number); end
    if (display_mask !== 8'hFF)    begin failures++; $display("FAIL %s display_mask: got %h want ff", tag, display_mask); end
    if (display_update !== 1'b0)   begin failures++; $display("FAIL %s display_update: got %b want 0", tag, display_update); end
    if (busy !== 1'b0)             begin failures++; $display("FAIL %s busy: got %b want 0", tag, busy); end
    if (timeout_flag !== 1'b0)     begin failures++; $display("FAIL %s timeout_flag: got %b want 0", tag, timeout_flag); end
    if (drop_count !== 8'h0)       begin failures++; $display("FAIL %s drop_count: got %h want 00", tag, drop_count); end
  endtask

  task automatic compare_stream(input string tag);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s stream_len: got %0d want %0d", tag, obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL %s stream[%0d]: got start=%b data=%h want start=%b data=%h",
                   tag, i, obs_q[i].start, obs_q[i].data, exp_q[i].start, exp_q[i].data);
        end
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Feeds one full frame of random samples with random idle gaps between them.
  task automatic send_frame(input int max_gap);
    for (int i = 0; i < FRAME_LEN; i++) begin
      logic [15:0] s;
      int          gap;
      s   = 16'($urandom);
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      sample_valid = 1'b0;
      repeat (gap) tick();
      sample_valid = 1'b1;
      sample_in    = s;
      exp_q.push_back({(i == 0), s});
      tick();
    end
    sample_valid = 1'b0;
  endtask

  // Waits n_wait cycles in WAIT_RESULT, delivers a result, then runs out the hold-off.
  task automatic finish_frame(input string tag, input int n_wait, input int amp,
                              input bit clr, input bit with_drops);
    for (int i = 0; i < n_wait; i++) begin
      sample_valid = with_drops;
      sample_in    = 16'($urandom);
      tick();
      if (with_drops) drops_raw++;
    end
    sample_valid  = with_drops;
    fft_valid     = 1'b1;
    fft_amplitude = 9'(amp);
    clear_peak    = clr;
    tick();
    if (with_drops) drops_raw++;
    fft_valid  = 1'b0;
    clear_peak = 1'b0;
    exp_amp  = amp;
    exp_peak = clr ? amp : ((amp > exp_peak) ? amp : exp_peak);
    checks += 3;
    if (display_number !== model_number()) begin failures++; $display("FAIL %s result_number: got %h want %h", tag, display_number, model_number()); end
    if (display_mask !== model_mask())     begin failures++; $display("FAIL %s result_mask: got %h want %h", tag, display_mask, model_mask()); end
    if (display_update !== 1'b1)           begin failures++; $display("FAIL %s result_update: got %b want 1", tag, display_update); end
    for (int i = 0; i < HOLD_CYCLES; i++) begin
      tick();
      if (with_drops) drops_raw++;
      if (i == 0) begin
        checks++;
        if (display_update !== 1'b0) begin failures++; $display("FAIL %s update_pulse_width: got %b want 0", tag, display_update); end
      end
      if (i == HOLD_CYCLES - 2) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_in_hold: got %b want 1", tag, busy); end
      end
    end
    sample_valid = 1'b0;
    checks += 2;
    if (busy !== enable)            begin failures++; $display("FAIL %s busy_after_hold: got %b want %b", tag, busy, enable); end
    if (drop_count !== model_drops()) begin failures++; $display("FAIL %s drop_count: got %0d want %0d", tag, drop_count, model_drops()); end
    compare_stream(tag);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    expect_reset_outputs("reset");
    reset = 1'b0;
    tick();
    expect_reset_outputs("after_release_idle");
  endtask

  task automatic test_ignored_in_idle();
    fft_valid     = 1'b1;
    fft_amplitude = 9'd511;
    tick();
    fft_valid = 1'b0;
    checks += 2;
    if (display_number !== 32'h0) begin failures++; $display("FAIL idle_fft_valid_number: got %h want 00000000", display_number); end
    if (display_update !== 1'b0)  begin failures++; $display("FAIL idle_fft_valid_update: got %b want 0", display_update); end
  endtask

  task automatic test_first_frame();
    logic [15:0] vals [4];
    vals = '{16'd10, 16'd20, 16'd30, 16'd40};
    enable = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL first_busy: got %b want 1", busy); end
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1;
      sample_in    = vals[i];
      tick();
      exp_q.push_back({(i == 0), vals[i]});
      checks += 3;
      if (fft_data !== vals[i])        begin failures++; $display("FAIL first_data[%0d]: got %0d want %0d", i, fft_data, vals[i]); end
      if (fft_data_valid !== 1'b1)     begin failures++; $display("FAIL first_valid[%0d]: got %b want 1", i, fft_data_valid); end
      if (fft_start !== (i == 0))      begin failures++; $display("FAIL first_start[%0d]: got %b want %b", i, fft_start, (i == 0)); end
    end
    sample_valid = 1'b0;
    finish_frame("first_frame", 3, 300, 1'b0, 1'b0);
    checks++;
    if (display_number !== 32'h012C012C) begin failures++; $display("FAIL first_display: got %h want 012c012c", display_number); end
  endtask

  task automatic test_second_frame_and_clear();
    send_frame(0);
    finish_frame("second_frame", int'($urandom_range(10, 0)), 100, 1'b0, 1'b0);
    checks++;
    if (display_number !== 32'h012C0064) begin failures++; $display("FAIL second_display: got %h want 012c0064", display_number); end
    clear_peak = 1'b1;
    tick();
    clear_peak = 1'b0;
    exp_peak = 0;
    checks += 3;
    if (display_number !== 32'h00000064) begin failures++; $display("FAIL clear_number: got %h want 00000064", display_number); end
    if (display_mask !== 8'hF0)          begin failures++; $display("FAIL clear_mask: got %h want f0", display_mask); end
    if (display_update !== 1'b1)         begin failures++; $display("FAIL clear_update: got %b want 1", display_update); end
    tick();
    checks++;
    if (display_update !== 1'b0) begin failures++; $display("FAIL clear_update_width: got %b want 0", display_update); end
  endtask

  task automatic test_ignored_in_collect();
    fft_valid     = 1'b1;
    fft_amplitude = 9'd511;
    tick();
    fft_valid = 1'b0;
    checks += 2;
    if (display_number !== model_number()) begin failures++; $display("FAIL collect_fft_valid_number: got %h want %h", display_number, model_number()); end
    if (display_update !== 1'b0)           begin failures++; $display("FAIL collect_fft_valid_update: got %b want 0", display_update); end
  endtask

  task automatic test_valid_beats_timeout();
    send_frame(1);
    finish_frame("valid_wins", TIMEOUT_CYCLES - 1, 77, 1'b0, 1'b0);
    checks++;
    if (timeout_flag !== 1'b0) begin failures++; $display("FAIL valid_wins_flag: got %b want 0", timeout_flag); end
  endtask

  task automatic test_timeout();
    int          pulses_before;
    logic [31:0] number_before;
    send_frame(1);
    pulses_before = update_pulses;
    number_before = model_number();
    repeat (TIMEOUT_CYCLES - 1) tick();
    checks++;
    if (timeout_flag !== 1'b0) begin failures++; $display("FAIL timeout_early: got %b want 0", timeout_flag); end
    tick();
    checks += 5;
    if (timeout_flag !== 1'b1)            begin failures++; $display("FAIL timeout_flag: got %b want 1", timeout_flag); end
    if (busy !== 1'b1)                    begin failures++; $display("FAIL timeout_busy: got %b want 1", busy); end
    if (display_number !== number_before) begin failures++; $display("FAIL timeout_display: got %h want %h", display_number, number_before); end
    if (display_update !== 1'b0)          begin failures++; $display("FAIL timeout_update: got %b want 0", display_update); end
    if (update_pulses != pulses_before)   begin failures++; $display("FAIL timeout_update_count: got %0d want %0d", update_pulses, pulses_before); end
    send_frame(0);
    finish_frame("after_timeout", 4, int'($urandom_range(511, 0)), 1'b0, 1'b0);
    checks++;
    if (timeout_flag !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %b want 1", timeout_flag); end
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 20; n++) begin
      enable = ($urandom_range(3, 0) != 0);
      send_frame(2);
      finish_frame("random_frame", int'($urandom_range(TIMEOUT_CYCLES - 1, 0)),
                   int'($urandom_range(511, 0)), ($urandom_range(3, 0) == 0),
                   bit'($urandom_range(1, 0)));
      if (!enable) begin
        enable = 1'b1;
        tick();
      end
    end
  endtask

  task automatic test_drop_saturate();
    while (drops_raw < 300) begin
      send_frame(0);
      finish_frame("drop_frame", TIMEOUT_CYCLES - 1, int'($urandom_range(511, 0)), 1'b0, 1'b1);
    end
    checks++;
    if (drop_count !== 8'd255) begin failures++; $display("FAIL drop_saturated: got %0d want 255", drop_count); end
  endtask

  task automatic test_reset_mid_frame();
    sample_valid = 1'b1;
    sample_in    = 16'h1234;
    tick();
    sample_in    = 16'h5678;
    tick();
    sample_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    expect_reset_outputs("mid_frame_reset");
    obs_q.delete();
    exp_q.delete();
    exp_amp   = 0;
    exp_peak  = 0;
    drops_raw = 0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL restart_busy: got %b want 1", busy); end
    send_frame(0);
    finish_frame("restart_frame", 2, int'($urandom_range(511, 1)), 1'b0, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    enable        = 1'b0;
    clear_peak    = 1'b0;
    sample_in     = 16'h0;
    sample_valid  = 1'b0;
    fft_valid     = 1'b0;
    fft_amplitude = 9'h0;

    test_reset();
    test_ignored_in_idle();
    test_first_frame();
    test_second_frame_and_clear();
    test_ignored_in_collect();
    test_valid_beats_timeout();
    test_timeout();
    test_random_frames();
    test_drop_saturate();
    test_reset_mid_frame();

    checks++;
    if (stray_starts != 0) begin failures++; $display("FAIL stray_fft_start: got %0d want 0", stray_starts); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
